// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - I-cache, D-cache and cacheline-adaptor signals of the cache arbiter
interface cache_arbiter_if;
  logic [31:0]  i_address;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;

  logic [31:0]  d_address;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;

  logic [31:0]  adpt_address;
  logic         adpt_read;
  logic         adpt_write;
  logic [255:0] adpt_wdata;
  logic [255:0] adpt_rdata;
  logic         adpt_resp;

  modport slave (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata, adpt_rdata, adpt_resp,
    output i_rdata, i_resp, d_rdata, d_resp, adpt_address, adpt_read, adpt_write, adpt_wdata
  );

  modport master (
    output i_address, i_read, d_address, d_read, d_write, d_wdata, adpt_rdata, adpt_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, adpt_address, adpt_read, adpt_write, adpt_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one cacheline adaptor between I-cache and D-cache
module cache_arbiter (
  input  logic           clk,
  input  logic           reset_n,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = I-cache served last, 1 = D-cache

  logic         i_pend, d_pend;
  logic         a_read, a_write, i_resp, d_resp;
  logic [31:0]  a_address;
  logic [255:0] a_wdata;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Downstream strobes come only from the registered state; resp is a combinational pass-through.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_read       = 1'b0;
    a_write      = 1'b0;
    a_address    = 32'd0;
    a_wdata      = 256'd0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_pend && d_pend) begin
          state_d = last_grant_q ? SERVE_I : SERVE_D;
        end else if (i_pend) begin
          state_d = SERVE_I;
        end else if (d_pend) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        a_read    = 1'b1;
        a_address = bus.i_address;
        if (bus.adpt_resp) begin
          i_resp       = 1'b1;
          last_grant_d = 1'b0;
          state_d      = RELEASE;
        end
      end
      SERVE_D: begin
        a_address = bus.d_address;
        a_wdata   = bus.d_wdata;
        a_write   = bus.d_write;
        a_read    = bus.d_read & ~bus.d_write;  // write-back wins an illegal read+write
        if (bus.adpt_resp) begin
          d_resp       = 1'b1;
          last_grant_d = 1'b1;
          state_d      = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.adpt_read    = a_read;
  assign bus.adpt_write   = a_write;
  assign bus.adpt_address = a_address;
  assign bus.adpt_wdata   = a_wdata;
  assign bus.i_resp       = i_resp;
  assign bus.d_resp       = d_resp;
  assign bus.i_rdata      = bus.adpt_rdata;
  assign bus.d_rdata      = bus.adpt_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter with a memory-backed adaptor model
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int illegal_seen = 0;
  bit auto_adpt = 1'b0;
  logic r1 = 1'b0;
  logic r2 = 1'b0;

  logic [255:0] i_exp[$];
  logic [256:0] d_exp[$];   // bit 256 = write-back
  int           grant_log[$];
  logic [255:0] amem[logic [31:0]];
  logic [255:0] d_ref[logic [31:0]];

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic i_txn(input logic [31:0] a, input logic [255:0] exp);
    int n = 0;
    i_exp.push_back(exp);
    bus.i_address = a;
    bus.i_read    = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.i_resp && n < 300);
    check_b("i_txn_completed", bus.i_resp, 1'b1);
    @(posedge clk);
    #1;
    bus.i_read = 1'b0;
  endtask

  task automatic d_txn(input logic w, input logic [31:0] a, input logic [255:0] wd);
    int n = 0;
    if (w) begin
      d_exp.push_back({1'b1, 256'd0});
      d_ref[a] = wd;
    end else begin
      d_exp.push_back({1'b0, d_ref.exists(a) ? d_ref[a] : line_of(a)});
    end
    bus.d_address = a;
    bus.d_wdata   = wd;
    bus.d_write   = w;
    bus.d_read    = ~w;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.d_resp && n < 300);
    check_b("d_txn_completed", bus.d_resp, 1'b1);
    @(posedge clk);
    #1;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every resp and watches protocol rules each cycle.
  always @(negedge clk) begin
    logic [256:0] e;
    if (!reset_n) begin
      r1 = 1'b0;
      r2 = 1'b0;
    end else begin
      cyc++;
      check_b("rd_wr_exclusive", bus.adpt_read & bus.adpt_write, 1'b0);
      check_b("resp_exclusive", bus.i_resp & bus.d_resp, 1'b0);
      check("i_rdata_mirror", bus.i_rdata, bus.adpt_rdata);
      check("d_rdata_mirror", bus.d_rdata, bus.adpt_rdata);
      if (r1 || r2) check_b("quiet_after_resp", bus.adpt_read | bus.adpt_write, 1'b0);
      if (bus.i_resp) begin
        check_b("i_resp_while_reading", bus.adpt_read & ~bus.adpt_write, 1'b1);
        check("i_addr_forwarded", 256'(bus.adpt_address), 256'(bus.i_address));
        check_b("i_resp_expected", i_exp.size() != 0, 1'b1);
        if (i_exp.size() != 0) check("i_rdata", bus.i_rdata, i_exp.pop_front());
        grant_log.push_back(0);
      end
      if (bus.d_resp) begin
        check_b("d_resp_while_active", bus.adpt_read | bus.adpt_write, 1'b1);
        check("d_addr_forwarded", 256'(bus.adpt_address), 256'(bus.d_address));
        check_b("d_resp_expected", d_exp.size() != 0, 1'b1);
        if (d_exp.size() != 0) begin
          e = d_exp.pop_front();
          check_b("d_kind", bus.adpt_write, e[256]);
          if (!e[256]) check("d_rdata", bus.d_rdata, e[255:0]);
        end
        grant_log.push_back(1);
      end
      if (bus.d_read && bus.d_write) begin
        illegal_seen++;
        $display("note: illegal d_read and d_write both asserted at cycle %0d", cyc);
      end
      r2 = r1;
      r1 = bus.i_resp | bus.d_resp;
    end
  end

  // Adaptor model: memory-backed, random latency, resets its data to random filler after each resp.
  initial begin
    logic [31:0]  a;
    logic         w;
    logic [255:0] wd;
    forever begin
      @(negedge clk);
      if (auto_adpt && reset_n && (bus.adpt_read || bus.adpt_write) && !bus.adpt_resp) begin
        a  = bus.adpt_address;
        w  = bus.adpt_write;
        wd = bus.adpt_wdata;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bus.adpt_rdata = w ? rand_line() : (amem.exists(a) ? amem[a] : line_of(a));
        if (w) amem[a] = wd;
        bus.adpt_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.adpt_resp  = 1'b0;
        bus.adpt_rdata = rand_line();
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d failures", checks, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] wd;
    int cyc_end;
    bus.i_address  = '0;
    bus.i_read     = 1'b0;
    bus.d_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_wdata    = '0;
    bus.adpt_resp  = 1'b0;
    bus.adpt_rdata = rand_line();
    reset_n        = 1'b0;

    // Reset state, with requests already present
    repeat (2) @(posedge clk);
    #1;
    bus.i_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_wdata = rand_line();
    #1;
    check_b("rst_adpt_read", bus.adpt_read, 1'b0);
    check_b("rst_adpt_write", bus.adpt_write, 1'b0);
    check_b("rst_i_resp", bus.i_resp, 1'b0);
    check_b("rst_d_resp", bus.d_resp, 1'b0);
    check("rst_adpt_address", 256'(bus.adpt_address), 256'd0);
    check("rst_adpt_wdata", bus.adpt_wdata, 256'd0);
    check("rst_i_rdata_mirror", bus.i_rdata, bus.adpt_rdata);
    bus.i_read  = 1'b0;
    bus.d_write = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single I read, adaptor resp at cycle 5
    i_exp.push_back({32{8'hA5}});
    bus.i_address = 32'h0000_0060;
    bus.i_read    = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c == 5) begin
        bus.adpt_resp  = 1'b1;
        bus.adpt_rdata = {32{8'hA5}};
      end
      @(negedge clk);
      check_b($sformatf("t1_adpt_read_c%0d", c), bus.adpt_read, (c >= 1 && c <= 5));
      check_b($sformatf("t1_adpt_write_c%0d", c), bus.adpt_write, 1'b0);
      check("t1_adpt_address", 256'(bus.adpt_address), (c >= 1 && c <= 5) ? 256'h60 : 256'h0);
      check_b($sformatf("t1_i_resp_c%0d", c), bus.i_resp, (c == 5));
      check_b("t1_d_resp", bus.d_resp, 1'b0);
      @(posedge clk);
      #1;
      if (c == 5) begin
        bus.adpt_resp  = 1'b0;
        bus.adpt_rdata = rand_line();
        bus.i_read     = 1'b0;
      end
    end

    // D write-back, adaptor resp at cycle 8
    wd = {16{16'h1234}};
    d_exp.push_back({1'b1, 256'd0});
    bus.d_address = 32'h0000_1000;
    bus.d_wdata   = wd;
    bus.d_write   = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 8) bus.adpt_resp = 1'b1;
      @(negedge clk);
      check_b($sformatf("t2_adpt_write_c%0d", c), bus.adpt_write, (c >= 1 && c <= 8));
      check_b($sformatf("t2_adpt_read_c%0d", c), bus.adpt_read, 1'b0);
      check("t2_adpt_address", 256'(bus.adpt_address), (c >= 1 && c <= 8) ? 256'h1000 : 256'h0);
      check("t2_adpt_wdata", bus.adpt_wdata, (c >= 1 && c <= 8) ? wd : 256'h0);
      check_b($sformatf("t2_d_resp_c%0d", c), bus.d_resp, (c == 8));
      check_b("t2_i_resp", bus.i_resp, 1'b0);
      @(posedge clk);
      #1;
      if (c == 8) begin
        bus.adpt_resp = 1'b0;
        bus.d_write   = 1'b0;
      end
    end

    // Contention straight after reset: both keep re-requesting
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    auto_adpt = 1'b1;
    grant_log.delete();
    fork
      for (int k = 0; k < 3; k++) i_txn(32'h100 + 32'(k * 32), line_of(32'h100 + 32'(k * 32)));
      for (int k = 0; k < 3; k++) d_txn(1'b0, 32'h1000_0000 + 32'(k * 32), 256'd0);
    join
    check("t3_grant_count", 256'(grant_log.size()), 256'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) check($sformatf("t3_grant_%0d", k), 256'(grant_log[k]), 256'(k % 2));
    end

    // Reset while a write-back is outstanding
    auto_adpt = 1'b0;
    @(posedge clk);
    #1;
    bus.d_address = 32'h0000_2000;
    bus.d_wdata   = rand_line();
    bus.d_write   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_b("t4_write_before_reset", bus.adpt_write, 1'b1);
    #1;
    reset_n       = 1'b0;
    bus.adpt_resp = 1'b1;
    bus.i_address = 32'h0000_0300;
    bus.i_read    = 1'b1;
    #1;
    check_b("t4_write_dropped", bus.adpt_write, 1'b0);
    check_b("t4_read_dropped", bus.adpt_read, 1'b0);
    check_b("t4_no_d_resp", bus.d_resp, 1'b0);
    check_b("t4_no_i_resp", bus.i_resp, 1'b0);
    @(posedge clk);
    #1;
    bus.adpt_resp = 1'b0;
    reset_n       = 1'b1;
    auto_adpt     = 1'b1;
    grant_log.delete();
    wd = bus.d_wdata;
    fork
      i_txn(32'h0000_0300, line_of(32'h0000_0300));
      d_txn(1'b1, 32'h0000_2000, wd);
    join
    check("t4_first_grant_i", 256'(grant_log.size() > 0 ? grant_log[0] : -1), 256'd0);

    // Illegal read+write from the D-cache
    auto_adpt = 1'b0;
    @(posedge clk);
    #1;
    illegal_seen = 0;
    d_exp.push_back({1'b1, 256'd0});
    bus.d_address = 32'h0000_3000;
    bus.d_wdata   = rand_line();
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    repeat (2) @(negedge clk);
    check_b("t5_adpt_write", bus.adpt_write, 1'b1);
    check_b("t5_adpt_read", bus.adpt_read, 1'b0);
    @(posedge clk);
    #1;
    bus.adpt_resp = 1'b1;
    @(negedge clk);
    check_b("t5_d_resp", bus.d_resp, 1'b1);
    @(posedge clk);
    #1;
    bus.adpt_resp = 1'b0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    check_b("t5_illegal_flagged", illegal_seen > 0, 1'b1);

    // Random traffic from both caches
    auto_adpt = 1'b1;
    cyc_end   = cyc + 10000;
    fork
      begin
        logic [31:0] a;
        while (cyc < cyc_end) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          a = 32'($urandom_range(0, 63)) << 5;
          i_txn(a, line_of(a));
        end
      end
      begin
        logic [31:0] a;
        while (cyc < cyc_end) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          a = 32'h1000_0000 + (32'($urandom_range(0, 7)) << 5);
          d_txn(1'($urandom_range(0, 1)), a, rand_line());
        end
      end
    join

    repeat (4) @(posedge clk);
    check_b("i_scoreboard_drained", i_exp.size() == 0, 1'b1);
    check_b("d_scoreboard_drained", d_exp.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
